// File: rtl/lsu_if.sv
// LSU signal bundle: EXU input handshake, data-memory req/ack port and write-back outputs.
// The slave modport is the LSU side; the master modport is the EXU/memory/write-back side.
interface lsu_if;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i;
    logic [31:0] alu_out_i;
    logic [31:0] rs2_data_i;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        misalign_err;
    logic        bus_err;

    modport slave (
        input  in_valid, opcode_i, funct3_i, rd_i, alu_out_i, rs2_data_i, mem_rdata, mem_ack,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
               wb_valid, wb_we, wb_rd, wb_data, misalign_err, bus_err
    );

    modport master (
        output in_valid, opcode_i, funct3_i, rd_i, alu_out_i, rs2_data_i, mem_rdata, mem_ack,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
               wb_valid, wb_we, wb_rd, wb_data, misalign_err, bus_err
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: non-memory ops pass through in one cycle; loads/stores run a req/ack cycle
// with byte lanes, load extension, misalignment detection and an optional ack timeout.
module lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    lsu_if.slave bus
);
    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_REQ     = 1'b1;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [1:0] SZ_B      = 2'd0;
    localparam logic [1:0] SZ_H      = 2'd1;
    localparam logic [1:0] SZ_W      = 2'd2;
    localparam int         CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [0:0]    state_q, state_d;
    logic          req_q, req_d, we_q, we_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic [4:0]    rd_q, rd_d;
    logic [1:0]    sz_q, sz_d, lane_q, lane_d;
    logic          sgn_q, sgn_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wb_vld_q, wb_vld_d, wb_we_q, wb_we_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic [31:0]   wb_dat_q, wb_dat_d;
    logic          mis_q, mis_d, berr_q, berr_d;

    logic          fire, is_ld, is_st, misal, expire;
    logic [1:0]    a, sz;
    logic [31:0]   shifted, ld_data;

    assign fire  = bus.in_valid && (state_q == S_IDLE);
    assign is_ld = (bus.opcode_i == OP_LOAD);
    assign is_st = (bus.opcode_i == OP_STORE);
    assign a     = bus.alu_out_i[1:0];

    // Unknown funct3 codes collapse to word width for both loads and stores.
    always_comb begin
        sz = SZ_W;
        if (is_ld) begin
            case (bus.funct3_i)
                3'b000, 3'b100: sz = SZ_B;
                3'b001, 3'b101: sz = SZ_H;
                default:        sz = SZ_W;
            endcase
        end else begin
            case (bus.funct3_i)
                3'b000:  sz = SZ_B;
                3'b001:  sz = SZ_H;
                default: sz = SZ_W;
            endcase
        end
    end

    assign misal  = ((sz == SZ_H) && a[0]) || ((sz == SZ_W) && (a != 2'b00));
    assign expire = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        shifted = bus.mem_rdata >> {lane_q, 3'b000};
        ld_data = shifted;
        case (sz_q)
            SZ_B:    ld_data = {{24{sgn_q & shifted[7]}}, shifted[7:0]};
            SZ_H:    ld_data = {{16{sgn_q & shifted[15]}}, shifted[15:0]};
            default: ld_data = shifted;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        rd_d     = rd_q;
        sz_d     = sz_q;
        sgn_d    = sgn_q;
        lane_d   = lane_q;
        cnt_d    = cnt_q;
        wb_vld_d = 1'b0;
        wb_we_d  = wb_we_q;
        wb_rd_d  = wb_rd_q;
        wb_dat_d = wb_dat_q;
        mis_d    = 1'b0;
        berr_d   = 1'b0;
        if (state_q == S_IDLE) begin
            if (fire && (is_ld || is_st) && misal) begin
                wb_vld_d = 1'b1;
                wb_we_d  = 1'b0;
                wb_rd_d  = bus.rd_i;
                wb_dat_d = bus.alu_out_i;
                mis_d    = 1'b1;
            end else if (fire && (is_ld || is_st)) begin
                state_d = S_REQ;
                req_d   = 1'b1;
                we_d    = is_st;
                addr_d  = {bus.alu_out_i[31:2], 2'b00};
                rd_d    = bus.rd_i;
                sz_d    = sz;
                sgn_d   = is_ld && (bus.funct3_i[2] == 1'b0);
                lane_d  = a;
                cnt_d   = '0;
                wstrb_d = 4'b0000;
                wdata_d = bus.rs2_data_i;
                if (is_st) begin
                    case (sz)
                        SZ_B: begin
                            wstrb_d = 4'b0001 << a;
                            wdata_d = {4{bus.rs2_data_i[7:0]}};
                        end
                        SZ_H: begin
                            wstrb_d = 4'b0011 << a;
                            wdata_d = {2{bus.rs2_data_i[15:0]}};
                        end
                        default: wstrb_d = 4'hF;
                    endcase
                end
            end else if (fire) begin
                wb_vld_d = 1'b1;
                wb_we_d  = (bus.opcode_i != OP_BRANCH) && (bus.rd_i != 5'd0);
                wb_rd_d  = bus.rd_i;
                wb_dat_d = bus.alu_out_i;
            end
        end else begin
            // An ack on the expiry edge completes normally.
            if (bus.mem_ack) begin
                state_d  = S_IDLE;
                req_d    = 1'b0;
                we_d     = 1'b0;
                wstrb_d  = 4'b0000;
                wb_vld_d = 1'b1;
                wb_we_d  = !we_q && (rd_q != 5'd0);
                wb_rd_d  = rd_q;
                wb_dat_d = we_q ? 32'd0 : ld_data;
            end else if (expire) begin
                state_d  = S_IDLE;
                req_d    = 1'b0;
                we_d     = 1'b0;
                wstrb_d  = 4'b0000;
                wb_vld_d = 1'b1;
                wb_we_d  = 1'b0;
                wb_rd_d  = rd_q;
                wb_dat_d = 32'd0;
                berr_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rd_q     <= '0;
            sz_q     <= '0;
            sgn_q    <= 1'b0;
            lane_q   <= '0;
            cnt_q    <= '0;
            wb_vld_q <= 1'b0;
            wb_we_q  <= 1'b0;
            wb_rd_q  <= '0;
            wb_dat_q <= '0;
            mis_q    <= 1'b0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            rd_q     <= rd_d;
            sz_q     <= sz_d;
            sgn_q    <= sgn_d;
            lane_q   <= lane_d;
            cnt_q    <= cnt_d;
            wb_vld_q <= wb_vld_d;
            wb_we_q  <= wb_we_d;
            wb_rd_q  <= wb_rd_d;
            wb_dat_q <= wb_dat_d;
            mis_q    <= mis_d;
            berr_q   <= berr_d;
        end
    end

    assign bus.in_ready     = (state_q == S_IDLE);
    assign bus.mem_req      = req_q;
    assign bus.mem_we       = we_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_wstrb    = wstrb_q;
    assign bus.wb_valid     = wb_vld_q;
    assign bus.wb_we        = wb_we_q;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_dat_q;
    assign bus.misalign_err = mis_q;
    assign bus.bus_err      = berr_q;
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: pass-through, store lanes, load extension, misalignment,
// ack timeout and asynchronous reset during a request.
module tb_lsu;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    lsu_if bus();

    lsu #(.TIMEOUT(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] rs2);
        chk("in_ready_before_issue", 32'(bus.in_ready), 1);
        bus.in_valid   = 1'b1;
        bus.opcode_i   = op;
        bus.funct3_i   = f3;
        bus.rd_i       = rd;
        bus.alu_out_i  = alu;
        bus.rs2_data_i = rs2;
        step();
        bus.in_valid   = 1'b0;
    endtask

    task automatic do_load(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [31:0] exp, input int wait_cyc);
        issue(OP_LOAD, f3, rd, addr, 32'h0);
        chk({tag, "_req"}, 32'(bus.mem_req), 1);
        chk({tag, "_we"}, 32'(bus.mem_we), 0);
        chk({tag, "_wstrb"}, 32'(bus.mem_wstrb), 0);
        chk({tag, "_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
        for (int i = 0; i < wait_cyc; i++) step();
        bus.mem_rdata = rdata;
        bus.mem_ack   = 1'b1;
        step();
        bus.mem_ack   = 1'b0;
        chk({tag, "_wb_valid"}, 32'(bus.wb_valid), 1);
        chk({tag, "_wb_data"}, bus.wb_data, exp);
        chk({tag, "_wb_we"}, 32'(bus.wb_we), (rd != 5'd0) ? 1 : 0);
        chk({tag, "_wb_rd"}, 32'(bus.wb_rd), 32'(rd));
        chk({tag, "_req_drop"}, 32'(bus.mem_req), 0);
    endtask

    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] rs2, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata, input int hold);
        issue(OP_STORE, f3, 5'd9, addr, rs2);
        for (int i = 0; i < hold; i++) begin
            chk({tag, "_req"}, 32'(bus.mem_req), 1);
            chk({tag, "_we"}, 32'(bus.mem_we), 1);
            chk({tag, "_addr"}, bus.mem_addr, {addr[31:2], 2'b00});
            chk({tag, "_wstrb"}, 32'(bus.mem_wstrb), 32'(exp_strb));
            chk({tag, "_wdata"}, bus.mem_wdata, exp_wdata);
            chk({tag, "_no_wb"}, 32'(bus.wb_valid), 0);
            if (i == hold - 1) bus.mem_ack = 1'b1;
            step();
            bus.mem_ack = 1'b0;
        end
        chk({tag, "_wb_valid"}, 32'(bus.wb_valid), 1);
        chk({tag, "_wb_we"}, 32'(bus.wb_we), 0);
        chk({tag, "_req_drop"}, 32'(bus.mem_req), 0);
    endtask

    initial begin
        int n;
        bus.in_valid   = 1'b0;
        bus.opcode_i   = '0;
        bus.funct3_i   = '0;
        bus.rd_i       = '0;
        bus.alu_out_i  = '0;
        bus.rs2_data_i = '0;
        bus.mem_rdata  = '0;
        bus.mem_ack    = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        chk("rst_mem_req", 32'(bus.mem_req), 0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 0);
        chk("rst_misalign", 32'(bus.misalign_err), 0);
        chk("rst_bus_err", 32'(bus.bus_err), 0);
        chk("rst_wstrb", 32'(bus.mem_wstrb), 0);
        chk("rst_wb_data", bus.wb_data, 0);
        rst = 1'b0;
        step();

        // Pass-through ops
        issue(OP_IMM, 3'b000, 5'd5, 32'h1234, 32'h0);
        chk("addi_wb_valid", 32'(bus.wb_valid), 1);
        chk("addi_wb_we", 32'(bus.wb_we), 1);
        chk("addi_wb_data", bus.wb_data, 32'h1234);
        chk("addi_wb_rd", 32'(bus.wb_rd), 5);
        chk("addi_mem_req", 32'(bus.mem_req), 0);
        issue(OP_IMM, 3'b000, 5'd0, 32'h5678, 32'h0);
        chk("addi_x0_wb_valid", 32'(bus.wb_valid), 1);
        chk("addi_x0_wb_we", 32'(bus.wb_we), 0);
        chk("addi_x0_wb_data", bus.wb_data, 32'h5678);
        issue(OP_BRANCH, 3'b000, 5'd3, 32'h1, 32'h0);
        chk("br_wb_valid", 32'(bus.wb_valid), 1);
        chk("br_wb_we", 32'(bus.wb_we), 0);
        step();
        chk("wb_valid_pulse", 32'(bus.wb_valid), 0);

        // Stores
        do_store("sb", 3'b000, 32'h102, 32'hAB, 4'b0100, 32'hABABABAB, 3);
        do_store("sh", 3'b001, 32'h42, 32'hBEEF1234, 4'b1100, 32'h12341234, 1);
        do_store("sw", 3'b010, 32'h40, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 2);

        // Loads
        do_load("lb", 3'b000, 5'd7, 32'h203, 32'h80000000, 32'hFFFFFF80, 0);
        do_load("lbu", 3'b100, 5'd7, 32'h203, 32'h80000000, 32'h00000080, 1);
        do_load("lhu", 3'b101, 5'd8, 32'h202, 32'h80000000, 32'h00008000, 0);
        do_load("lh", 3'b001, 5'd8, 32'h202, 32'h80000000, 32'hFFFF8000, 2);
        do_load("lb_pos", 3'b000, 5'd4, 32'h201, 32'h00007F00, 32'h0000007F, 0);
        do_load("lw_x0", 3'b010, 5'd0, 32'h200, 32'h12345678, 32'h12345678, 0);
        do_load("lw_unk", 3'b111, 5'd6, 32'h204, 32'hCAFEF00D, 32'hCAFEF00D, 0);

        // Misaligned
        issue(OP_LOAD, 3'b010, 5'd6, 32'h101, 32'h0);
        chk("mis_lw_err", 32'(bus.misalign_err), 1);
        chk("mis_lw_wb_valid", 32'(bus.wb_valid), 1);
        chk("mis_lw_wb_we", 32'(bus.wb_we), 0);
        chk("mis_lw_req", 32'(bus.mem_req), 0);
        chk("mis_lw_in_ready", 32'(bus.in_ready), 1);
        step();
        chk("mis_lw_err_pulse", 32'(bus.misalign_err), 0);
        chk("mis_lw_req_later", 32'(bus.mem_req), 0);
        issue(OP_STORE, 3'b001, 5'd0, 32'h203, 32'h1);
        chk("mis_sh_err", 32'(bus.misalign_err), 1);
        chk("mis_sh_req", 32'(bus.mem_req), 0);
        step();

        // Timeout with no ack
        issue(OP_LOAD, 3'b010, 5'd10, 32'h300, 32'h0);
        n = 0;
        while (bus.mem_req && n < 40) begin
            n++;
            step();
        end
        chk("to_req_cycles", 32'(n), 16);
        chk("to_bus_err", 32'(bus.bus_err), 1);
        chk("to_wb_valid", 32'(bus.wb_valid), 1);
        chk("to_wb_we", 32'(bus.wb_we), 0);
        chk("to_in_ready", 32'(bus.in_ready), 1);
        step();
        chk("to_bus_err_pulse", 32'(bus.bus_err), 0);

        // Ack on the expiry edge completes normally
        issue(OP_LOAD, 3'b010, 5'd11, 32'h304, 32'h0);
        for (int i = 0; i < 15; i++) begin
            chk("to16_req_held", 32'(bus.mem_req), 1);
            step();
        end
        chk("to16_req_last", 32'(bus.mem_req), 1);
        bus.mem_rdata = 32'h0BADCAFE;
        bus.mem_ack   = 1'b1;
        step();
        bus.mem_ack   = 1'b0;
        chk("to16_wb_valid", 32'(bus.wb_valid), 1);
        chk("to16_bus_err", 32'(bus.bus_err), 0);
        chk("to16_wb_data", bus.wb_data, 32'h0BADCAFE);
        chk("to16_wb_we", 32'(bus.wb_we), 1);

        // Reset in the middle of a request
        issue(OP_LOAD, 3'b010, 5'd12, 32'h400, 32'h0);
        step();
        chk("rstmid_req_before", 32'(bus.mem_req), 1);
        #3 rst = 1'b1;
        #1;
        chk("rstmid_req_async", 32'(bus.mem_req), 0);
        chk("rstmid_in_ready", 32'(bus.in_ready), 1);
        step();
        rst = 1'b0;
        chk("rstmid_no_wb", 32'(bus.wb_valid), 0);
        bus.mem_rdata = 32'hFFFFFFFF;
        bus.mem_ack   = 1'b1;
        step();
        bus.mem_ack   = 1'b0;
        chk("rstmid_stray_ack_wb", 32'(bus.wb_valid), 0);
        chk("rstmid_stray_ack_req", 32'(bus.mem_req), 0);
        do_load("post_rst_lw", 3'b010, 5'd13, 32'h404, 32'h13572468, 32'h13572468, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
